btn_debounce_fsm: RTL and testbench

Producer side of the switch/button input consumed by the LED and stopwatch FSMs. It takes a raw, asynchronous, bouncing mechanical input and synchronizes it to clk. A debounce state machine then drives a clean level plus single-cycle rise/fall event pulses. Every board button/switch feeding a control FSM passes through one instance.

---
 rtl/btn_pkg.sv | 19 +
 rtl/sync_ff.sv | 23 ++
 rtl/btn_debounce_fsm.sv | 136 +++++++++++++
 tb/tb_btn_debounce_fsm.sv | 251 +++++++++++++++++++++++++
 4 files changed

// File: rtl/btn_pkg.sv
// Shared constants and state encoding for the button debouncer.
package btn_pkg;

    localparam logic [1:0] ST_IDLE_LOW  = 2'd0;
    localparam logic [1:0] ST_WAIT_HIGH = 2'd1;
    localparam logic [1:0] ST_IDLE_HIGH = 2'd2;
    localparam logic [1:0] ST_WAIT_LOW  = 2'd3;

    localparam int unsigned DEBOUNCE_10MS_100MHZ = 1000000;
    localparam int unsigned LONG_1S_100MHZ       = 100000000;

    typedef enum logic [1:0] {
        StIdleLow  = ST_IDLE_LOW,
        StWaitHigh = ST_WAIT_HIGH,
        StIdleHigh = ST_IDLE_HIGH,
        StWaitLow  = ST_WAIT_LOW
    } btn_state_e;

endpackage

// File: rtl/sync_ff.sv
// Multi-flop synchronizer for asynchronous single-bit inputs; resets to 0.
module sync_ff #(
    parameter int unsigned STAGES = 2
) (
    input  logic clk,
    input  logic reset,
    input  logic d,
    output logic q
);

    logic [STAGES-1:0] chain;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            chain <= '0;
        end else begin
            chain <= {chain[STAGES-2:0], d};
        end
    end

    assign q = chain[STAGES-1];

endmodule

// File: rtl/btn_debounce_fsm.sv
// Synchronizes and debounces a raw button into a clean level plus rise/fall pulses.
// Define BTN_LONG_PRESS_EN to build the long-press detector driving btn_long.
module btn_debounce_fsm
    import btn_pkg::*;
#(
    parameter int unsigned SYNC_STAGES   = 2,
    parameter int unsigned STABLE_CYCLES = DEBOUNCE_10MS_100MHZ,
    parameter int unsigned LONG_CYCLES   = LONG_1S_100MHZ
) (
    input  logic clk,
    input  logic reset,
    input  logic btn_in,
    output logic btn_level,
    output logic btn_rise,
    output logic btn_fall,
    output logic btn_long
);

    localparam int unsigned      CNT_W    = $clog2(STABLE_CYCLES + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(STABLE_CYCLES - 1);

    if (SYNC_STAGES < 2 || SYNC_STAGES > 4) begin : g_bad_sync
        $error("SYNC_STAGES must be in 2..4");
    end
    if (STABLE_CYCLES < 2) begin : g_bad_stable
        $error("STABLE_CYCLES must be at least 2");
    end
    if (LONG_CYCLES < 1) begin : g_bad_long
        $error("LONG_CYCLES must be at least 1");
    end

    logic             s;
    btn_state_e       state;
    logic [CNT_W-1:0] cnt;

    sync_ff #(
        .STAGES(SYNC_STAGES)
    ) u_sync (
        .clk  (clk),
        .reset(reset),
        .d    (btn_in),
        .q    (s)
    );

    // Every exit from a WAIT state clears cnt, so it never passes CNT_LAST.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state     <= StIdleLow;
            cnt       <= '0;
            btn_level <= 1'b0;
            btn_rise  <= 1'b0;
            btn_fall  <= 1'b0;
        end else begin
            btn_rise <= 1'b0;
            btn_fall <= 1'b0;
            case (state)
                StIdleLow: begin
                    if (s) begin
                        state <= StWaitHigh;
                        cnt   <= CNT_W'(1);
                    end else begin
                        cnt <= '0;
                    end
                end
                StWaitHigh: begin
                    if (!s) begin
                        state <= StIdleLow;
                        cnt   <= '0;
                    end else if (cnt == CNT_LAST) begin
                        state     <= StIdleHigh;
                        cnt       <= '0;
                        btn_level <= 1'b1;
                        btn_rise  <= 1'b1;
                    end else begin
                        cnt <= cnt + CNT_W'(1);
                    end
                end
                StIdleHigh: begin
                    if (!s) begin
                        state <= StWaitLow;
                        cnt   <= CNT_W'(1);
                    end else begin
                        cnt <= '0;
                    end
                end
                StWaitLow: begin
                    if (s) begin
                        state <= StIdleHigh;
                        cnt   <= '0;
                    end else if (cnt == CNT_LAST) begin
                        state     <= StIdleLow;
                        cnt       <= '0;
                        btn_level <= 1'b0;
                        btn_fall  <= 1'b1;
                    end else begin
                        cnt <= cnt + CNT_W'(1);
                    end
                end
                default: begin
                    state <= StIdleLow;
                    cnt   <= '0;
                end
            endcase
        end
    end

`ifdef BTN_LONG_PRESS_EN
    localparam int unsigned       HOLD_W    = $clog2(LONG_CYCLES + 1);
    localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(LONG_CYCLES - 1);
    localparam logic [HOLD_W-1:0] HOLD_SAT  = HOLD_W'(LONG_CYCLES);

    logic [HOLD_W-1:0] hold_cnt;
    logic              hold_active;

    assign hold_active = (state == StIdleHigh) || (state == StWaitLow);

    // Saturating at LONG_CYCLES gives one pulse per press; cleared while low.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            hold_cnt <= '0;
            btn_long <= 1'b0;
        end else begin
            btn_long <= 1'b0;
            if (!hold_active) begin
                hold_cnt <= '0;
            end else if (hold_cnt != HOLD_SAT) begin
                hold_cnt <= hold_cnt + HOLD_W'(1);
                btn_long <= (hold_cnt == HOLD_LAST);
            end
        end
    end
`else
    assign btn_long = 1'b0;
`endif

endmodule

// File: tb/tb_btn_debounce_fsm.sv
// Directed bench for btn_debounce_fsm with SYNC_STAGES=2, STABLE_CYCLES=4, LONG_CYCLES=10.
module tb_btn_debounce_fsm;

    localparam int unsigned SYNC_STAGES   = 2;
    localparam int unsigned STABLE_CYCLES = 4;
    localparam int unsigned LONG_CYCLES   = 10;
`ifdef BTN_LONG_PRESS_EN
    localparam logic LONG_EN = 1'b1;
`else
    localparam logic LONG_EN = 1'b0;
`endif

    logic clk = 1'b0;
    logic reset;
    logic btn_in;
    logic btn_level, btn_rise, btn_fall, btn_long;

    int vectors = 0;
    int errors = 0;
    int rise_total = 0;
    int fall_total = 0;
    int long_total = 0;
    int both_total = 0;

    btn_debounce_fsm #(
        .SYNC_STAGES  (SYNC_STAGES),
        .STABLE_CYCLES(STABLE_CYCLES),
        .LONG_CYCLES  (LONG_CYCLES)
    ) dut (
        .clk      (clk),
        .reset    (reset),
        .btn_in   (btn_in),
        .btn_level(btn_level),
        .btn_rise (btn_rise),
        .btn_fall (btn_fall),
        .btn_long (btn_long)
    );

    always #5 clk = ~clk;

    // Pulse tally, sampled well clear of both clock edges.
    always @(posedge clk) begin
        #2;
        if (btn_rise === 1'b1) rise_total++;
        if (btn_fall === 1'b1) fall_total++;
        if (btn_long === 1'b1) long_total++;
        if (btn_rise === 1'b1 && btn_fall === 1'b1) both_total++;
    end

    task automatic wait_cycles(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic test_reset();
        reset  = 1'b1;
        btn_in = 1'b0;
        wait_cycles(2);
        vectors++;
        if (btn_level !== 1'b0) begin errors++; $display("FAIL reset_level got %b want 0", btn_level); end
        vectors++;
        if (btn_rise !== 1'b0) begin errors++; $display("FAIL reset_rise got %b want 0", btn_rise); end
        vectors++;
        if (btn_fall !== 1'b0) begin errors++; $display("FAIL reset_fall got %b want 0", btn_fall); end
        vectors++;
        if (btn_long !== 1'b0) begin errors++; $display("FAIL reset_long got %b want 0", btn_long); end
        reset = 1'b0;
        wait_cycles(4);
        vectors++;
        if (btn_level !== 1'b0) begin errors++; $display("FAIL idle_low_level got %b want 0", btn_level); end
    endtask

    // Clean step high; outputs update on the 6th edge counting the capture edge.
    task automatic test_clean_press();
        int r0, f0;
        r0 = rise_total;
        f0 = fall_total;
        btn_in = 1'b1;
        wait_cycles(5);
        vectors++;
        if (btn_level !== 1'b0) begin errors++; $display("FAIL press_early_level got %b want 0", btn_level); end
        wait_cycles(1);
        vectors++;
        if (btn_level !== 1'b1) begin errors++; $display("FAIL press_level got %b want 1", btn_level); end
        vectors++;
        if (btn_rise !== 1'b1) begin errors++; $display("FAIL press_rise got %b want 1", btn_rise); end
        vectors++;
        if (btn_fall !== 1'b0) begin errors++; $display("FAIL press_fall got %b want 0", btn_fall); end
        wait_cycles(1);
        vectors++;
        if (btn_rise !== 1'b0) begin errors++; $display("FAIL press_rise_clear got %b want 0", btn_rise); end
        wait_cycles(3);
        vectors++;
        if (rise_total - r0 !== 1) begin errors++; $display("FAIL press_rise_count got %0d want 1", rise_total - r0); end
        vectors++;
        if (fall_total - f0 !== 0) begin errors++; $display("FAIL press_fall_count got %0d want 0", fall_total - f0); end
    endtask

    task automatic test_release();
        int f0, r0;
        f0 = fall_total;
        r0 = rise_total;
        btn_in = 1'b0;
        wait_cycles(5);
        vectors++;
        if (btn_level !== 1'b1) begin errors++; $display("FAIL release_early_level got %b want 1", btn_level); end
        wait_cycles(1);
        vectors++;
        if (btn_level !== 1'b0) begin errors++; $display("FAIL release_level got %b want 0", btn_level); end
        vectors++;
        if (btn_fall !== 1'b1) begin errors++; $display("FAIL release_fall got %b want 1", btn_fall); end
        wait_cycles(1);
        vectors++;
        if (btn_fall !== 1'b0) begin errors++; $display("FAIL release_fall_clear got %b want 0", btn_fall); end
        wait_cycles(2);
        vectors++;
        if (fall_total - f0 !== 1) begin errors++; $display("FAIL release_fall_count got %0d want 1", fall_total - f0); end
        vectors++;
        if (rise_total - r0 !== 0) begin errors++; $display("FAIL release_rise_count got %0d want 0", rise_total - r0); end
    endtask

    task automatic test_bounce();
        int r0;
        r0 = rise_total;
        btn_in = 1'b1; wait_cycles(1);
        btn_in = 1'b0; wait_cycles(1);
        btn_in = 1'b1; wait_cycles(1);
        btn_in = 1'b0; wait_cycles(1);
        btn_in = 1'b1;
        wait_cycles(5);
        vectors++;
        if (btn_level !== 1'b0) begin errors++; $display("FAIL bounce_early_level got %b want 0", btn_level); end
        vectors++;
        if (rise_total - r0 !== 0) begin errors++; $display("FAIL bounce_no_pulse got %0d want 0", rise_total - r0); end
        wait_cycles(1);
        vectors++;
        if (btn_rise !== 1'b1) begin errors++; $display("FAIL bounce_rise got %b want 1", btn_rise); end
        wait_cycles(4);
        vectors++;
        if (rise_total - r0 !== 1) begin errors++; $display("FAIL bounce_rise_count got %0d want 1", rise_total - r0); end
        vectors++;
        if (btn_level !== 1'b1) begin errors++; $display("FAIL bounce_level got %b want 1", btn_level); end
    endtask

    task automatic test_glitch();
        int r0, f0;
        r0 = rise_total;
        f0 = fall_total;
        btn_in = 1'b1;
        wait_cycles(3);
        btn_in = 1'b0;
        wait_cycles(3);
        vectors++;
        if (btn_level !== 1'b0) begin errors++; $display("FAIL glitch_mid_level got %b want 0", btn_level); end
        wait_cycles(8);
        vectors++;
        if (btn_level !== 1'b0) begin errors++; $display("FAIL glitch_level got %b want 0", btn_level); end
        vectors++;
        if (rise_total - r0 !== 0) begin errors++; $display("FAIL glitch_rise_count got %0d want 0", rise_total - r0); end
        vectors++;
        if (fall_total - f0 !== 0) begin errors++; $display("FAIL glitch_fall_count got %0d want 0", fall_total - f0); end
    endtask

    task automatic test_reset_mid();
        int r0;
        r0 = rise_total;
        btn_in = 1'b1;
        wait_cycles(4);
        reset = 1'b1;
        #1;
        vectors++;
        if ({btn_level, btn_rise, btn_fall, btn_long} !== 4'b0000) begin
            errors++;
            $display("FAIL reset_mid_outputs got %b want 0000", {btn_level, btn_rise, btn_fall, btn_long});
        end
        wait_cycles(2);
        reset = 1'b0;
        vectors++;
        if (rise_total - r0 !== 0) begin errors++; $display("FAIL reset_mid_no_pulse got %0d want 0", rise_total - r0); end
        wait_cycles(5);
        vectors++;
        if (btn_level !== 1'b0) begin errors++; $display("FAIL reset_mid_early_level got %b want 0", btn_level); end
        wait_cycles(1);
        vectors++;
        if (btn_rise !== 1'b1) begin errors++; $display("FAIL reset_mid_rise got %b want 1", btn_rise); end
        wait_cycles(3);
        vectors++;
        if (rise_total - r0 !== 1) begin errors++; $display("FAIL reset_mid_rise_count got %0d want 1", rise_total - r0); end
    endtask

    task automatic test_reset_high();
        reset = 1'b1;
        #1;
        vectors++;
        if (btn_level !== 1'b0) begin errors++; $display("FAIL reset_high_level got %b want 0", btn_level); end
        wait_cycles(1);
        btn_in = 1'b0;
        reset  = 1'b0;
        wait_cycles(8);
        vectors++;
        if (btn_level !== 1'b0) begin errors++; $display("FAIL reset_high_after got %b want 0", btn_level); end
    endtask

    // IDLE_HIGH is entered on the rise edge; btn_long follows 10 edges later.
    task automatic test_long_press();
        int l0;
        l0 = long_total;
        btn_in = 1'b1;
        wait_cycles(6);
        vectors++;
        if (btn_rise !== 1'b1) begin errors++; $display("FAIL long_rise got %b want 1", btn_rise); end
        wait_cycles(9);
        vectors++;
        if (btn_long !== 1'b0) begin errors++; $display("FAIL long_early got %b want 0", btn_long); end
        wait_cycles(1);
        vectors++;
        if (btn_long !== LONG_EN) begin errors++; $display("FAIL long_pulse got %b want %b", btn_long, LONG_EN); end
        wait_cycles(1);
        vectors++;
        if (btn_long !== 1'b0) begin errors++; $display("FAIL long_clear got %b want 0", btn_long); end
        wait_cycles(19);
        vectors++;
        if (long_total - l0 !== int'(LONG_EN)) begin
            errors++;
            $display("FAIL long_count got %0d want %0d", long_total - l0, int'(LONG_EN));
        end
        vectors++;
        if (btn_level !== 1'b1) begin errors++; $display("FAIL long_level got %b want 1", btn_level); end
    endtask

    task automatic test_no_overlap();
        vectors++;
        if (both_total !== 0) begin errors++; $display("FAIL rise_fall_overlap got %0d want 0", both_total); end
    endtask

    initial begin
        test_reset();
        test_clean_press();
        test_release();
        test_bounce();
        test_release();
        test_glitch();
        test_reset_mid();
        test_release();
        test_long_press();
        test_reset_high();
        test_no_overlap();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

endmodule
